// File: rtl/sdram_read_single.sv
// sdram_read_single: single-word SDRAM read sequencer for a device set up as CL2, BL1,
// sequential. It is the read-side counterpart of the init sequencer.
//
// On an accepted request it issues ACTIVE, READ and then PRECHARGE, and it captures one
// 16-bit word from DRAM_DQ. It shares the SDRAM pins with the other sequencers: when ienb
// is low, every DRAM_* output is released to Z.
//
// Optional feature: define SDRAM_READ_AUTOPRE_EN to issue READ with A10=1 (auto-precharge).
// The capture-edge command then becomes NOP instead of PRECHARGE. All timing is unchanged.
//
// Parameters
//   TRCD     ACTIVE->READ spacing in cycles (>= 1)
//   CAS_LAT  READ->capture spacing in cycles (2 or 3, must match the mode register)
//   TRP      PRECHARGE->idle spacing in cycles (>= 1)
//
// Ports
//   iclk, ireset_n      clock; asynchronous active-low reset
//   ireq, iaddr         read request and {bank[23:22], row[21:9], col[8:0]}, taken only in idle
//   ienb                bus ownership; 0 tri-states all DRAM_* outputs
//   odata, ovalid       captured word (held) and its one-cycle valid pulse
//   obusy               transaction in progress
//   DRAM_*              SDRAM command/address pins; DRAM_DQ is input-only here
module sdram_read_single #(
    parameter int unsigned TRCD    = 2,
    parameter int unsigned CAS_LAT = 2,
    parameter int unsigned TRP     = 2
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        ireq,
    input  logic        ienb,
    input  logic [23:0] iaddr,
    output logic [15:0] odata,
    output logic        ovalid,
    output logic        obusy,
    output wire logic        DRAM_CLK,
    output wire logic        DRAM_CKE,
    output wire logic [12:0] DRAM_ADDR,
    output wire logic [1:0]  DRAM_BA,
    output wire logic        DRAM_CS_N,
    output wire logic        DRAM_RAS_N,
    output wire logic        DRAM_CAS_N,
    output wire logic        DRAM_WE_N,
    output wire logic        DRAM_LDQM,
    output wire logic        DRAM_UDQM,
    input  logic [15:0] DRAM_DQ
);

    typedef enum logic [2:0] {
        StIdle,
        StAct,
        StWrcd,
        StRd,
        StWcas,
        StPre,
        StWrp
    } state_e;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CmdNop = 4'b0111;
    localparam logic [3:0] CmdAct = 4'b0011;
    localparam logic [3:0] CmdRd  = 4'b0101;
    localparam logic [3:0] CmdPre = 4'b0010;

`ifdef SDRAM_READ_AUTOPRE_EN
    localparam logic       ReadA10 = 1'b1;
    localparam logic [3:0] CapCmd  = CmdNop;
`else
    localparam logic       ReadA10 = 1'b0;
    localparam logic [3:0] CapCmd  = CmdPre;
`endif

    // Wait states check the counter before incrementing, so the terminal values are one
    // or two below the parameter: the command state that follows adds its own edge.
    localparam logic [3:0] RcdEnd = (TRCD > 1) ? 4'(TRCD - 2) : 4'd0;
    localparam logic [3:0] CasEnd = 4'(CAS_LAT - 2);
    localparam logic [3:0] RpEnd  = 4'(TRP - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  bank_q, bank_d;
    logic [12:0] row_q, row_d;
    logic [8:0]  col_q, col_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [1:0]  ba_q, ba_d;
    logic [12:0] addr_q, addr_d;
    logic [1:0]  dqm_q, dqm_d;
    logic [15:0] odata_q, odata_d;
    logic        ovalid_q, ovalid_d;
    logic        obusy_q, obusy_d;

    logic accept;
    assign accept = ireq && ienb;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bank_d   = bank_q;
        row_d    = row_q;
        col_d    = col_q;
        cmd_d    = CmdNop;
        ba_d     = ba_q;
        addr_d   = '0;
        dqm_d    = dqm_q;
        odata_d  = odata_q;
        ovalid_d = 1'b0;
        obusy_d  = obusy_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    bank_d  = iaddr[23:22];
                    row_d   = iaddr[21:9];
                    col_d   = iaddr[8:0];
                    state_d = StAct;
                end
            end
            StAct: begin
                cmd_d   = CmdAct;
                ba_d    = bank_q;
                addr_d  = row_q;
                obusy_d = 1'b1;
                dqm_d   = 2'b00;
                cnt_d   = '0;
                state_d = (TRCD > 1) ? StWrcd : StRd;
            end
            StWrcd: begin
                if (cnt_q == RcdEnd) begin
                    state_d = StRd;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRd: begin
                cmd_d   = CmdRd;
                ba_d    = bank_q;
                addr_d  = {2'b00, ReadA10, 1'b0, col_q};
                cnt_d   = '0;
                state_d = StWcas;
            end
            StWcas: begin
                if (cnt_q == CasEnd) begin
                    state_d = StPre;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StPre: begin
                // Capture edge: data is on DQ now, and the row is closed on the same edge.
                odata_d  = DRAM_DQ;
                ovalid_d = 1'b1;
                cmd_d    = CapCmd;
                ba_d     = bank_q;
                cnt_d    = '0;
                state_d  = StWrp;
            end
            StWrp: begin
                if (cnt_q == RpEnd) begin
                    obusy_d = 1'b0;
                    dqm_d   = 2'b11;
                    cnt_d   = '0;
                    state_d = StIdle;
                    // A request present at completion starts the next read back-to-back.
                    if (accept) begin
                        bank_d  = iaddr[23:22];
                        row_d   = iaddr[21:9];
                        col_d   = iaddr[8:0];
                        state_d = StAct;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bank_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            cmd_q    <= CmdNop;
            ba_q     <= '0;
            addr_q   <= '0;
            dqm_q    <= 2'b11;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            obusy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cmd_q    <= cmd_d;
            ba_q     <= ba_d;
            addr_q   <= addr_d;
            dqm_q    <= dqm_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            obusy_q  <= obusy_d;
        end
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign obusy  = obusy_q;

    assign DRAM_CLK   = ienb ? iclk : 1'bz;
    assign DRAM_CKE   = ienb ? 1'b1 : 1'bz;
    assign DRAM_ADDR  = ienb ? addr_q : 13'bz;
    assign DRAM_BA    = ienb ? ba_q : 2'bz;
    assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
    assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
    assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
    assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
    assign DRAM_LDQM  = ienb ? dqm_q[0] : 1'bz;
    assign DRAM_UDQM  = ienb ? dqm_q[1] : 1'bz;

endmodule

// File: tb/tb_sdram_read_single.sv
// tb_sdram_read_single: directed and randomized reads checked against a timeline model
// derived from the command spacing (ACTIVE at +1, READ at +1+TRCD, capture at
// +1+TRCD+CAS_LAT, idle after TRP more cycles). Released bus lines are seen through
// pulled nets: tri1 on CS_N/ADDR/BA and tri0 on the rest, so Z differs from idle values.
module tb_sdram_read_single;

    localparam int TRCD    = 2;
    localparam int CAS_LAT = 2;
    localparam int TRP     = 2;
    localparam int CapK    = 1 + TRCD + CAS_LAT;
    localparam int DoneK   = CapK + TRP;

`ifdef SDRAM_READ_AUTOPRE_EN
    localparam logic AutoPre = 1'b1;
`else
    localparam logic AutoPre = 1'b0;
`endif

    localparam logic [3:0] Nop = 4'b0111;
    localparam logic [3:0] Act = 4'b0011;
    localparam logic [3:0] Rd  = 4'b0101;
    localparam logic [3:0] Pre = 4'b0010;

    logic        iclk     = 1'b0;
    logic        ireset_n = 1'b0;
    logic        ireq     = 1'b0;
    logic        ienb     = 1'b1;
    logic [23:0] iaddr    = '0;
    logic [15:0] dq       = '0;
    logic [15:0] odata;
    logic        ovalid;
    logic        obusy;

    tri0        dram_clk;
    tri0        dram_cke;
    tri1 [12:0] dram_addr;
    tri1 [1:0]  dram_ba;
    tri1        dram_cs_n;
    tri0        dram_ras_n;
    tri0        dram_cas_n;
    tri0        dram_we_n;
    tri0        dram_ldqm;
    tri0        dram_udqm;

    logic [3:0] bus_cmd;
    logic [1:0] bus_dqm;
    assign bus_cmd = {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n};
    assign bus_dqm = {dram_udqm, dram_ldqm};

    int          checks      = 0;
    int          errors      = 0;
    int          n_valid     = 0;
    logic [15:0] model_odata = '0;

    sdram_read_single #(
        .TRCD    (TRCD),
        .CAS_LAT (CAS_LAT),
        .TRP     (TRP)
    ) dut (
        .iclk       (iclk),
        .ireset_n   (ireset_n),
        .ireq       (ireq),
        .ienb       (ienb),
        .iaddr      (iaddr),
        .odata      (odata),
        .ovalid     (ovalid),
        .obusy      (obusy),
        .DRAM_CLK   (dram_clk),
        .DRAM_CKE   (dram_cke),
        .DRAM_ADDR  (dram_addr),
        .DRAM_BA    (dram_ba),
        .DRAM_CS_N  (dram_cs_n),
        .DRAM_RAS_N (dram_ras_n),
        .DRAM_CAS_N (dram_cas_n),
        .DRAM_WE_N  (dram_we_n),
        .DRAM_LDQM  (dram_ldqm),
        .DRAM_UDQM  (dram_udqm),
        .DRAM_DQ    (dq)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iclk);
            @(negedge iclk);
            check("idle obusy", 32'(obusy), 32'd0);
            check("idle ovalid", 32'(ovalid), 32'd0);
            check("idle cmd", 32'(bus_cmd), 32'(Nop));
            check("idle dqm", 32'(bus_dqm), 32'd3);
            check("idle odata", 32'(odata), 32'(model_odata));
        end
    endtask

    // One read, checked cycle by cycle from the accept edge. With accepted=1 the accept
    // edge was the previous transaction's completion edge. chain holds ireq high with
    // a_next; pulse_k>0 raises ireq for the edge after k.
    task automatic txn(input logic [23:0] a, input logic [15:0] d, input bit accepted,
                       input bit chain, input logic [23:0] a_next, input int pulse_k);
        logic [3:0]  e_cmd;
        logic [12:0] e_addr;
        bit          is_cmd;
        if (!accepted) begin
            ireq  = 1'b1;
            iaddr = a;
            @(posedge iclk);
            @(negedge iclk);
        end
        ireq  = chain;
        iaddr = chain ? a_next : 24'($urandom);
        dq    = 16'($urandom);
        for (int k = 1; k <= DoneK; k++) begin
            @(posedge iclk);
            @(negedge iclk);
            e_cmd  = Nop;
            e_addr = '0;
            is_cmd = 1'b0;
            if (k == 1) begin
                e_cmd  = Act;
                e_addr = a[21:9];
                is_cmd = 1'b1;
            end else if (k == 1 + TRCD) begin
                e_cmd  = Rd;
                e_addr = {2'b00, AutoPre, 1'b0, a[8:0]};
                is_cmd = 1'b1;
            end else if (k == CapK) begin
                e_cmd  = AutoPre ? Nop : Pre;
                is_cmd = 1'b1;
            end
            if (k == CapK) model_odata = d;
            check($sformatf("k%0d cmd", k), 32'(bus_cmd), 32'(e_cmd));
            check($sformatf("k%0d addr", k), 32'(dram_addr), 32'(e_addr));
            if (is_cmd) check($sformatf("k%0d ba", k), 32'(dram_ba), 32'(a[23:22]));
            check($sformatf("k%0d obusy", k), 32'(obusy), 32'(k < DoneK));
            check($sformatf("k%0d dqm", k), 32'(bus_dqm), (k < DoneK) ? 32'd0 : 32'd3);
            check($sformatf("k%0d ovalid", k), 32'(ovalid), 32'(k == CapK));
            check($sformatf("k%0d odata", k), 32'(odata), 32'(model_odata));
            if (ovalid === 1'b1) n_valid++;
            dq = (k + 1 == CapK) ? d : 16'($urandom);
            if (pulse_k != 0) ireq = chain || (k == pulse_k);
        end
    endtask

    initial begin
        logic [23:0] a0;
        logic [23:0] a1;

        // Reset values, while reset is held.
        repeat (2) @(negedge iclk);
        check("rst cmd", 32'(bus_cmd), 32'(Nop));
        check("rst dqm", 32'(bus_dqm), 32'd3);
        check("rst addr", 32'(dram_addr), 32'd0);
        check("rst ba", 32'(dram_ba), 32'd0);
        check("rst obusy", 32'(obusy), 32'd0);
        check("rst ovalid", 32'(ovalid), 32'd0);
        check("rst odata", 32'(odata), 32'd0);
        ireset_n = 1'b1;
        @(posedge iclk);
        #1;
        check("clk fwd", 32'(dram_clk), 32'd1);
        check("cke", 32'(dram_cke), 32'd1);
        idle_check(2);

        // Directed single read.
        txn({2'b10, 13'h0A5, 9'h03C}, 16'hBEEF, 1'b0, 1'b0, 24'h0, 0);
        idle_check(1);

        // Randomized reads, sometimes separated by an idle cycle.
        for (int i = 0; i < 12; i++) begin
            txn(24'($urandom), 16'($urandom), 1'b0, 1'b0, 24'h0, 0);
            if ($urandom_range(0, 1) == 1) idle_check(1);
        end

        // ireq held high across two transactions: back-to-back, ACTIVEs at t+1 and t+8.
        a0 = 24'($urandom);
        a1 = 24'($urandom);
        n_valid = 0;
        txn(a0, 16'($urandom), 1'b0, 1'b1, a1, 0);
        txn(a1, 16'($urandom), 1'b1, 1'b0, 24'h0, 0);
        check("b2b pulses", 32'(n_valid), 32'd2);
        idle_check(2);

        // Request pulsed mid-transaction is dropped, not queued.
        n_valid = 0;
        txn(24'($urandom), 16'h1234, 1'b0, 1'b0, 24'h0, 2);
        idle_check(4);
        check("pulse count", 32'(n_valid), 32'd1);

        // Bus not owned: no accept, all pins released.
        ienb  = 1'b0;
        ireq  = 1'b1;
        iaddr = 24'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge iclk);
            #1;
            check("z clk", 32'(dram_clk), 32'd0);
            @(negedge iclk);
            check("z obusy", 32'(obusy), 32'd0);
            check("z cmd", 32'(bus_cmd), 32'h8);
            check("z addr", 32'(dram_addr), 32'h1FFF);
            check("z ba", 32'(dram_ba), 32'h3);
            check("z dqm", 32'(bus_dqm), 32'd0);
            check("z cke", 32'(dram_cke), 32'd0);
        end
        ireq = 1'b0;
        ienb = 1'b1;
        idle_check(2);

        // Asynchronous reset in the middle of a read, right after READ goes out.
        ireq  = 1'b1;
        iaddr = 24'($urandom);
        @(posedge iclk);
        @(negedge iclk);
        ireq = 1'b0;
        repeat (1 + TRCD) @(posedge iclk);
        #2;
        check("pre-abort cmd", 32'(bus_cmd), 32'(Rd));
        ireset_n = 1'b0;
        #1;
        check("abort cmd", 32'(bus_cmd), 32'(Nop));
        check("abort dqm", 32'(bus_dqm), 32'd3);
        check("abort obusy", 32'(obusy), 32'd0);
        check("abort ovalid", 32'(ovalid), 32'd0);
        check("abort odata", 32'(odata), 32'd0);
        model_odata = '0;
        @(negedge iclk);
        ireset_n = 1'b1;
        idle_check(8);

        // Recovery after reset.
        txn(24'($urandom), 16'($urandom), 1'b0, 1'b0, 24'h0, 0);
        idle_check(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
